systolic_ctrl: RTL and testbench
================================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 16, meaning PE rows/columns and buffer count.
REQ-002 SHALL have parameter IFM_SIZE, default 64, meaning IFM height/width in pixels.
REQ-003 SHALL have parameter IFM_CHANNEL, default 3, meaning input channels per tile.
REQ-004 SHALL have parameter WEIGHT_SIZE, default 3, meaning kernel height/width.
REQ-005 SHALL have ports: clk  in  1  clock, rising edge; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: start  in  1  one-cycle pulse, begin full layer.
REQ-008 SHALL have ports: data_valid  in  1  source has IFM and weight beat available.
REQ-009 SHALL have ports: ifm_read_en, weight_read_en  out  1 each  request IFM/weight beat.
REQ-010 SHALL have ports: buf_wr_en  out  1  write accepted beat into skew buffers.
REQ-011 SHALL have ports: buf_wr_addr  out  $clog2(K)  beat index within channel, K = WEIGHT_SIZE*WEIGHT_SIZE.
REQ-012 SHALL have ports: pe_en  out  1  PE array MAC enable.
REQ-013 SHALL have ports: pe_clr  out  1  clear PE accumulators.
REQ-014 SHALL have ports: out_valid  out  1  PE column result shift-out strobe.
REQ-015 SHALL have ports: busy  out  1  FSM not IDLE.
REQ-016 SHALL have ports: done  out  1  one-cycle pulse, layer finished.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, COMPUTE, DRAIN, FINISH.
REQ-018 SHALL derive constants: K = WEIGHT_SIZE^2; COMPUTE_LEN = K + 2*SYSTOLIC_SIZE - 2; NUM_TILES = ceil((IFM_SIZE-WEIGHT_SIZE+1)^2 / SYSTOLIC_SIZE) (241 at defaults).
REQ-019 SHALL move IDLE->LOAD on start; pe_clr high exactly that transition cycle; start ignored when not IDLE.
REQ-020 SHALL in LOAD hold ifm_read_en = weight_read_en = 1; beat accepted when read_en & data_valid.
REQ-021 SHALL per accepted beat assert buf_wr_en same cycle with buf_wr_addr = beat count 0..K-1; data_valid low stalls count, no write.
REQ-022 SHALL LOAD->COMPUTE after beat K-1 accepted; read_en deasserted registered from next cycle.
REQ-023 SHALL in COMPUTE assert pe_en for exactly COMPUTE_LEN cycles (39 at defaults), then increment channel counter.
REQ-024 SHALL COMPUTE->LOAD if channel < IFM_CHANNEL-1, else COMPUTE->DRAIN with channel reset to 0.
REQ-025 SHALL in DRAIN assert out_valid for exactly SYSTOLIC_SIZE cycles, then increment tile counter.
REQ-026 SHALL DRAIN->LOAD with pe_clr high one cycle if tiles remain, else DRAIN->FINISH.
REQ-027 SHALL in FINISH pulse done for one cycle, then go to IDLE.
REQ-028 SHALL keep pe_en, out_valid, buf_wr_en, read_en mutually exclusive by state.
REQ-029 SHALL make all outputs registered except buf_wr_en and buf_wr_addr.

Reset
REQ-030 SHALL on rst_n low, asynchronously: state IDLE, all counters 0, all outputs 0, including mid-LOAD/COMPUTE/DRAIN.
REQ-031 SHALL resume only on a fresh start after release.

Configuration
REQ-032 SHALL with SYSTOLIC_CTRL_PERF_EN defined add output stall_cnt, 32 bits, counting LOAD cycles with data_valid low, cleared on start, saturating.
REQ-033 SHALL without SYSTOLIC_CTRL_PERF_EN have no stall_cnt port or logic; all other behaviour identical.

Structure
REQ-034 SHALL place state enum and derived constants K, COMPUTE_LEN, NUM_TILES in shared package systolic_pkg.
REQ-035 SHALL be a single module with no sub-modules; counters inline.

Verification
REQ-036 SHALL cover: reset, start, data_valid constantly 1 -> per channel 9 buf_wr_en (addr 0..8), 39 pe_en; after 3 channels 16 out_valid; done after 241 tiles.
REQ-037 SHALL cover: data_valid toggling 1/0 in LOAD -> 9 writes over 17 cycles, addr gaps-free; stall_cnt = 8 with macro.
REQ-038 SHALL cover: rst_n low mid-COMPUTE -> all outputs 0 immediately, busy 0; no activity until next start.
REQ-039 SHALL cover: start pulsed during DRAIN -> ignored, tile/channel counts unchanged.
REQ-040 SHALL cover: IFM_SIZE=18, SYSTOLIC_SIZE=16 -> NUM_TILES 16, done after 16 DRAIN phases.
REQ-041 SHALL cover: assertion checks -> pe_en/out_valid/buf_wr_en never overlap; done width exactly 1 cycle.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array controller: FSM state encoding
// and the layer-geometry constants (K, COMPUTE_LEN, NUM_TILES). The constants
// are provided both as helper functions of the module parameters and as
// localparams evaluated at the default geometry (16x16 array, 64x64 IFM,
// 3x3 kernel).
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        FINISH  = 3'd4
    } state_t;

    // Number of weight/IFM beats per channel: one per kernel tap.
    function automatic int calc_k(input int weight_size);
        return weight_size * weight_size;
    endfunction

    // MAC cycles per channel: the K taps plus the skew fill/flush of the
    // array along both dimensions.
    function automatic int calc_compute_len(input int weight_size, input int systolic_size);
        return weight_size * weight_size + 2 * systolic_size - 2;
    endfunction

    // Output pixels of a valid convolution, grouped SYSTOLIC_SIZE per tile
    // and rounded up so a partial last tile is still processed.
    function automatic int calc_num_tiles(input int ifm_size, input int weight_size,
                                          input int systolic_size);
        int out_dim;
        out_dim = ifm_size - weight_size + 1;
        return (out_dim * out_dim + systolic_size - 1) / systolic_size;
    endfunction

    localparam int K           = calc_k(3);
    localparam int COMPUTE_LEN = calc_compute_len(3, 16);
    localparam int NUM_TILES   = calc_num_tiles(64, 3, 16);

endpackage

// File: rtl/systolic_ctrl.sv
// Layer sequencer for a SYSTOLIC_SIZE x SYSTOLIC_SIZE PE array.
// For every output tile it loads K beats per input channel into the skew
// buffers, runs the MAC phase, repeats for all channels, then shifts the
// PE column results out. A one-cycle done pulse closes the layer.
// Optional feature: define SYSTOLIC_CTRL_PERF_EN to add the 32-bit
// stall_cnt output (LOAD cycles spent waiting on data_valid).
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int IFM_SIZE      = 64,
    parameter int IFM_CHANNEL   = 3,
    parameter int WEIGHT_SIZE   = 3,
    localparam int ADDR_W = (WEIGHT_SIZE * WEIGHT_SIZE > 1) ?
                            $clog2(WEIGHT_SIZE * WEIGHT_SIZE) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              data_valid,
    output logic              ifm_read_en,
    output logic              weight_read_en,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic              pe_en,
    output logic              pe_clr,
    output logic              out_valid,
    output logic              busy,
    output logic              done
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int BEATS = calc_k(WEIGHT_SIZE);
    localparam int CLEN  = calc_compute_len(WEIGHT_SIZE, SYSTOLIC_SIZE);
    localparam int TILES = calc_num_tiles(IFM_SIZE, WEIGHT_SIZE, SYSTOLIC_SIZE);

    // One shared cycle counter times both COMPUTE and DRAIN.
    localparam int CYC_MAX  = (CLEN > SYSTOLIC_SIZE) ? CLEN : SYSTOLIC_SIZE;
    localparam int CYC_W    = $clog2(CYC_MAX + 1);
    localparam int CH_W     = $clog2(IFM_CHANNEL + 1);
    localparam int TILE_W   = $clog2(TILES + 1);

    localparam logic [ADDR_W-1:0] LAST_BEAT    = ADDR_W'(BEATS - 1);
    localparam logic [CYC_W-1:0]  LAST_COMPUTE = CYC_W'(CLEN - 1);
    localparam logic [CYC_W-1:0]  LAST_DRAIN   = CYC_W'(SYSTOLIC_SIZE - 1);
    localparam logic [CH_W-1:0]   LAST_CH      = CH_W'(IFM_CHANNEL - 1);
    localparam logic [TILE_W-1:0] LAST_TILE    = TILE_W'(TILES - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [CYC_W-1:0]    cyc_cnt_reg, cyc_cnt_next;
    logic [CH_W-1:0]     ch_cnt_reg, ch_cnt_next;
    logic [TILE_W-1:0]   tile_cnt_reg, tile_cnt_next;
    logic                clr_next;

    logic                read_en_reg;
    logic                pe_en_reg;
    logic                pe_clr_reg;
    logic                out_valid_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                beat_accept;

    // read_en_reg is high exactly while in LOAD, so a beat is taken whenever
    // the source also has data; the write is combinational with that handshake.
    assign beat_accept = read_en_reg & data_valid;

    // Next-state and counter update logic.
    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        cyc_cnt_next  = cyc_cnt_reg;
        ch_cnt_next   = ch_cnt_reg;
        tile_cnt_next = tile_cnt_reg;
        clr_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = LOAD;
                    clr_next      = 1'b1;
                    beat_cnt_next = '0;
                    cyc_cnt_next  = '0;
                    ch_cnt_next   = '0;
                    tile_cnt_next = '0;
                end
            end

            LOAD: begin
                if (beat_accept) begin
                    if (beat_cnt_reg == LAST_BEAT) begin
                        beat_cnt_next = '0;
                        cyc_cnt_next  = '0;
                        state_next    = COMPUTE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end

            COMPUTE: begin
                if (cyc_cnt_reg == LAST_COMPUTE) begin
                    cyc_cnt_next = '0;
                    if (ch_cnt_reg == LAST_CH) begin
                        ch_cnt_next = '0;
                        state_next  = DRAIN;
                    end else begin
                        ch_cnt_next = ch_cnt_reg + 1'b1;
                        state_next  = LOAD;
                    end
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + 1'b1;
                end
            end

            DRAIN: begin
                if (cyc_cnt_reg == LAST_DRAIN) begin
                    cyc_cnt_next = '0;
                    if (tile_cnt_reg == LAST_TILE) begin
                        tile_cnt_next = '0;
                        state_next    = FINISH;
                    end else begin
                        // Next tile starts from empty accumulators.
                        tile_cnt_next = tile_cnt_reg + 1'b1;
                        clr_next      = 1'b1;
                        state_next    = LOAD;
                    end
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + 1'b1;
                end
            end

            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            cyc_cnt_reg  <= '0;
            ch_cnt_reg   <= '0;
            tile_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            cyc_cnt_reg  <= cyc_cnt_next;
            ch_cnt_reg   <= ch_cnt_next;
            tile_cnt_reg <= tile_cnt_next;
        end
    end

    // Output registers decoded from the next state, so each strobe is aligned
    // with the state it belongs to and the strobes are exclusive by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_en_reg   <= 1'b0;
            pe_en_reg     <= 1'b0;
            pe_clr_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            read_en_reg   <= (state_next == LOAD);
            pe_en_reg     <= (state_next == COMPUTE);
            pe_clr_reg    <= clr_next;
            out_valid_reg <= (state_next == DRAIN);
            busy_reg      <= (state_next != IDLE);
            done_reg      <= (state_next == FINISH);
        end
    end

    assign ifm_read_en    = read_en_reg;
    assign weight_read_en = read_en_reg;
    assign buf_wr_en      = beat_accept;
    assign buf_wr_addr    = beat_cnt_reg;
    assign pe_en          = pe_en_reg;
    assign pe_clr         = pe_clr_reg;
    assign out_valid      = out_valid_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] stall_cnt_reg;

    // Saturating count of LOAD cycles starved by the source; restarts per layer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            stall_cnt_reg <= '0;
        end else if (read_en_reg && !data_valid && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl. Instance A uses the default
// geometry (241 tiles); instance B uses an 18x18 IFM (16 tiles) for the
// randomized, per-cycle checks against a phase-timeline reference model.
`timescale 1ns/1ps
module tb_systolic_ctrl;

    localparam int S       = 16;
    localparam int CH      = 3;
    localparam int KK      = 3 * 3;
    localparam int CL      = KK + 2 * S - 2;
    localparam int TILES_A = ((64 - 3 + 1) * (64 - 3 + 1) + S - 1) / S;
    localparam int TILES_B = ((18 - 3 + 1) * (18 - 3 + 1) + S - 1) / S;
    localparam int MAXC    = 8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- DUT A (default geometry) ----------------
    logic       a_rst_n = 1'b0, a_start = 1'b0, a_dv = 1'b0;
    logic       a_ifm_rd, a_w_rd, a_wr_en, a_pe_en, a_pe_clr, a_ov, a_busy, a_done;
    logic [3:0] a_wr_addr;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] a_stall;
`endif

    systolic_ctrl #(.SYSTOLIC_SIZE(16), .IFM_SIZE(64), .IFM_CHANNEL(3), .WEIGHT_SIZE(3)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .data_valid(a_dv),
        .ifm_read_en(a_ifm_rd), .weight_read_en(a_w_rd), .buf_wr_en(a_wr_en),
        .buf_wr_addr(a_wr_addr), .pe_en(a_pe_en), .pe_clr(a_pe_clr),
        .out_valid(a_ov), .busy(a_busy), .done(a_done)
`ifdef SYSTOLIC_CTRL_PERF_EN
        , .stall_cnt(a_stall)
`endif
    );

    // ---------------- DUT B (18x18 IFM) ----------------
    logic       b_rst_n = 1'b0, b_start = 1'b0, b_dv = 1'b0;
    logic       b_ifm_rd, b_w_rd, b_wr_en, b_pe_en, b_pe_clr, b_ov, b_busy, b_done;
    logic [3:0] b_wr_addr;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] b_stall;
`endif

    systolic_ctrl #(.SYSTOLIC_SIZE(16), .IFM_SIZE(18), .IFM_CHANNEL(3), .WEIGHT_SIZE(3)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .data_valid(b_dv),
        .ifm_read_en(b_ifm_rd), .weight_read_en(b_w_rd), .buf_wr_en(b_wr_en),
        .buf_wr_addr(b_wr_addr), .pe_en(b_pe_en), .pe_clr(b_pe_clr),
        .out_valid(b_ov), .busy(b_busy), .done(b_done)
`ifdef SYSTOLIC_CTRL_PERF_EN
        , .stall_cnt(b_stall)
`endif
    );

    function automatic logic [11:0] a_vec();
        return {a_ifm_rd, a_w_rd, a_wr_en, a_wr_addr, a_pe_en, a_pe_clr, a_ov, a_busy, a_done};
    endfunction

    function automatic logic [11:0] b_vec();
        return {b_ifm_rd, b_w_rd, b_wr_en, b_wr_addr, b_pe_en, b_pe_clr, b_ov, b_busy, b_done};
    endfunction

    // ---------------- Reference model (phase timeline) ----------------
    // Cycle 0 is the first cycle after the clock edge that samples start.
    bit dv_pat   [MAXC];
    bit exp_rd   [MAXC];
    bit exp_wr   [MAXC];
    bit exp_pe   [MAXC];
    bit exp_ov   [MAXC];
    bit exp_clr  [MAXC];
    bit exp_done [MAXC];
    bit exp_busy [MAXC];
    int exp_addr [MAXC];
    int exp_stall[MAXC];
    int m_len, m_first_pe, m_first_ov;

    // mode 0: always valid, 1: ~75% valid, 2: ~50% valid, 3: alternating 1/0
    task automatic gen_dv(input int mode);
        for (int i = 0; i < MAXC; i++) begin
            case (mode)
                0:       dv_pat[i] = 1'b1;
                1:       dv_pat[i] = ($urandom_range(0, 3) != 0);
                2:       dv_pat[i] = ($urandom_range(0, 1) != 0);
                default: dv_pat[i] = (i % 2 == 0);
            endcase
            if (i >= 4000) dv_pat[i] = 1'b1;
        end
    endtask

    task automatic build_model(input int ntiles);
        int t, w, st;
        for (int i = 0; i < MAXC; i++) begin
            exp_rd[i] = 0; exp_wr[i] = 0; exp_pe[i] = 0; exp_ov[i] = 0;
            exp_clr[i] = 0; exp_done[i] = 0; exp_busy[i] = 0; exp_addr[i] = 0;
        end
        t = 0;
        m_first_pe = -1;
        m_first_ov = -1;
        for (int tl = 0; tl < ntiles; tl++) begin
            for (int ch = 0; ch < CH; ch++) begin
                if (ch == 0) exp_clr[t] = 1;
                w = 0;
                while (w < KK) begin
                    exp_rd[t] = 1;
                    if (dv_pat[t]) begin
                        exp_wr[t]   = 1;
                        exp_addr[t] = w;
                        w++;
                    end
                    t++;
                end
                if (m_first_pe < 0) m_first_pe = t;
                for (int c = 0; c < CL; c++) begin exp_pe[t] = 1; t++; end
            end
            if (m_first_ov < 0) m_first_ov = t;
            for (int c = 0; c < S; c++) begin exp_ov[t] = 1; t++; end
        end
        exp_done[t] = 1;
        t++;
        m_len = t;
        for (int i = 0; i < m_len; i++) exp_busy[i] = 1;
        st = 0;
        for (int i = 0; i < MAXC; i++) begin
            exp_stall[i] = st;
            if (exp_rd[i] && !dv_pat[i]) st++;
        end
    endtask

    // Runs one full layer on DUT B and compares every cycle with the model.
    task automatic run_layer_b(input string name, input int inject_at,
                               output int load_cycles, output int load_writes,
                               output int stall_at_pe, output int ov_phases,
                               output int done_pulses);
        logic [11:0] got, want, fgot, fwant;
        int errs, first, stall_errs, overlap;
        bit seen_pe, prev_ov;
        errs = 0; first = -1; stall_errs = 0; overlap = 0;
        seen_pe = 0; prev_ov = 0; fgot = '0; fwant = '0;
        load_cycles = 0; load_writes = 0; stall_at_pe = 0; ov_phases = 0; done_pulses = 0;

        @(negedge clk);
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        b_dv    = dv_pat[0];
        for (int i = 0; i < m_len + 4; i++) begin
            @(negedge clk);
            want = {exp_rd[i], exp_rd[i], exp_wr[i], exp_wr[i] ? 4'(exp_addr[i]) : 4'd0,
                    exp_pe[i], exp_clr[i], exp_ov[i], exp_busy[i], exp_done[i]};
            got  = {b_ifm_rd, b_w_rd, b_wr_en, exp_wr[i] ? b_wr_addr : 4'd0,
                    b_pe_en, b_pe_clr, b_ov, b_busy, b_done};
            if (got !== want) begin
                errs++;
                if (first < 0) begin first = i; fgot = got; fwant = want; end
            end
            if (int'(b_pe_en) + int'(b_ov) + int'(b_wr_en) > 1) overlap++;
`ifdef SYSTOLIC_CTRL_PERF_EN
            if (b_stall !== exp_stall[i]) stall_errs++;
`endif
            if (!seen_pe) begin
                if (b_pe_en) begin
                    seen_pe = 1;
`ifdef SYSTOLIC_CTRL_PERF_EN
                    stall_at_pe = int'(b_stall);
`endif
                end else begin
                    if (b_ifm_rd) load_cycles++;
                    if (b_wr_en)  load_writes++;
                end
            end
            if (b_ov && !prev_ov) ov_phases++;
            prev_ov = b_ov;
            if (b_done) done_pulses++;
            @(posedge clk);
            #1;
            b_dv    = dv_pat[i + 1];
            b_start = (i + 1 == inject_at);
        end
        b_start = 1'b0;

        n_assert++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL %s_timeline: %0d cycles differ, first at cycle %0d got %b required %b",
                     name, errs, first, fgot, fwant);
        end
        n_assert++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL %s_overlap: %0d overlapping cycles, required 0", name, overlap);
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        n_assert++;
        if (stall_errs != 0) begin
            n_fail++;
            $display("FAIL %s_stall_cnt: %0d cycles wrong, required 0", name, stall_errs);
        end
`endif
        $display("layer %s: %0d cycles, %0d drain phases, %0d done pulses",
                 name, m_len, ov_phases, done_pulses);
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
        a_dv = 1'b0; b_dv = 1'b0;
        repeat (3) @(negedge clk);
        n_assert++;
        if (a_vec() !== 12'd0) begin
            n_fail++; $display("FAIL reset_a: outputs %b required 0", a_vec());
        end
        n_assert++;
        if (b_vec() !== 12'd0) begin
            n_fail++; $display("FAIL reset_b: outputs %b required 0", b_vec());
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        n_assert++;
        if (a_stall !== 32'd0) begin
            n_fail++; $display("FAIL reset_stall: %0d required 0", a_stall);
        end
`endif
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        a_dv = 1'b1; b_dv = 1'b1;
        repeat (4) @(negedge clk);
        n_assert++;
        if (a_vec() !== 12'd0 || b_vec() !== 12'd0) begin
            n_fail++; $display("FAIL idle_no_start: a %b b %b required 0", a_vec(), b_vec());
        end
        $display("reset: both instances idle");
    endtask

    task automatic test_full_layer_default();
        int cyc, done_at, done_cnt, wr, pe, ov, clr, busy_c, addr_err, overlap;
        int pe_run, ov_run, bad_pe, bad_ov, wr_since, bad_chan, drains;
        int exp_total;
        bit prev_pe, prev_ov;
        done_at = -1; done_cnt = 0; wr = 0; pe = 0; ov = 0; clr = 0; busy_c = 0;
        addr_err = 0; overlap = 0; pe_run = 0; ov_run = 0; bad_pe = 0; bad_ov = 0;
        wr_since = 0; bad_chan = 0; drains = 0; prev_pe = 0; prev_ov = 0;
        exp_total = TILES_A * (CH * (KK + CL) + S);

        @(negedge clk);
        a_start = 1'b1; a_dv = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        for (cyc = 0; cyc < exp_total + 200; cyc++) begin
            @(negedge clk);
            if (a_wr_en) begin
                if (int'(a_wr_addr) != wr % KK) addr_err++;
                wr++; wr_since++;
            end
            if (a_pe_en) begin
                if (!prev_pe) begin
                    if (wr_since != KK) bad_chan++;
                    wr_since = 0;
                end
                pe++; pe_run++;
            end else if (prev_pe) begin
                if (pe_run != CL) bad_pe++;
                pe_run = 0;
            end
            if (a_ov) begin
                if (!prev_ov) drains++;
                ov++; ov_run++;
            end else if (prev_ov) begin
                if (ov_run != S) bad_ov++;
                ov_run = 0;
            end
            if (a_pe_clr) clr++;
            if (a_busy) busy_c++;
            if (a_done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (int'(a_pe_en) + int'(a_ov) + int'(a_wr_en) > 1) overlap++;
            prev_pe = a_pe_en;
            prev_ov = a_ov;
            if (done_at >= 0 && cyc >= done_at + 3) break;
        end

        n_assert++;
        if (done_at != exp_total) begin
            n_fail++; $display("FAIL default_done_cycle: %0d required %0d (-1 means timeout)", done_at, exp_total);
        end
        n_assert++;
        if (done_cnt != 1) begin
            n_fail++; $display("FAIL default_done_width: %0d done cycles required 1", done_cnt);
        end
        n_assert++;
        if (wr != TILES_A * CH * KK || addr_err != 0 || bad_chan != 0) begin
            n_fail++; $display("FAIL default_writes: %0d writes (required %0d), %0d addr errors, %0d bad channels",
                               wr, TILES_A * CH * KK, addr_err, bad_chan);
        end
        n_assert++;
        if (pe != TILES_A * CH * CL || bad_pe != 0) begin
            n_fail++; $display("FAIL default_pe_en: %0d cycles (required %0d), %0d bad runs", pe, TILES_A * CH * CL, bad_pe);
        end
        n_assert++;
        if (ov != TILES_A * S || bad_ov != 0 || drains != TILES_A) begin
            n_fail++; $display("FAIL default_out_valid: %0d cycles in %0d phases (required %0d in %0d), %0d bad runs",
                               ov, drains, TILES_A * S, TILES_A, bad_ov);
        end
        n_assert++;
        if (clr != TILES_A) begin
            n_fail++; $display("FAIL default_pe_clr: %0d required %0d", clr, TILES_A);
        end
        n_assert++;
        if (busy_c != exp_total + 1) begin
            n_fail++; $display("FAIL default_busy: %0d cycles required %0d", busy_c, exp_total + 1);
        end
        n_assert++;
        if (overlap != 0) begin
            n_fail++; $display("FAIL default_overlap: %0d cycles required 0", overlap);
        end
        $display("layer default: done at cycle %0d, %0d tiles drained", done_at, drains);
    endtask

    task automatic test_random_dv();
        int lc, lw, sp, ovp, dp;
        gen_dv(1);
        build_model(TILES_B);
        run_layer_b("random75", -1, lc, lw, sp, ovp, dp);
        gen_dv(2);
        build_model(TILES_B);
        run_layer_b("random50", -1, lc, lw, sp, ovp, dp);
        n_assert++;
        if (lw != KK) begin
            n_fail++; $display("FAIL random_first_load_writes: %0d required %0d", lw, KK);
        end
    endtask

    task automatic test_toggle_dv();
        int lc, lw, sp, ovp, dp;
        gen_dv(3);
        build_model(TILES_B);
        run_layer_b("toggle", -1, lc, lw, sp, ovp, dp);
        n_assert++;
        if (lc != 17 || lw != 9) begin
            n_fail++; $display("FAIL toggle_first_load: %0d writes over %0d cycles, required 9 over 17", lw, lc);
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        n_assert++;
        if (sp != 8) begin
            n_fail++; $display("FAIL toggle_stall_cnt: %0d required 8", sp);
        end
`endif
    endtask

    task automatic test_start_in_drain();
        int lc, lw, sp, ovp, dp;
        gen_dv(1);
        build_model(TILES_B);
        run_layer_b("start_in_drain", m_first_ov + 5, lc, lw, sp, ovp, dp);
        n_assert++;
        if (ovp != TILES_B || dp != 1) begin
            n_fail++; $display("FAIL start_in_drain_counts: %0d drains %0d done, required %0d and 1", ovp, dp, TILES_B);
        end
    endtask

    task automatic test_reset_mid_compute();
        int lc, lw, sp, ovp, dp, idle_err;
        gen_dv(0);
        build_model(TILES_B);
        @(negedge clk);
        b_start = 1'b1; b_dv = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        for (int i = 0; i < m_first_pe + 10; i++) @(posedge clk);
        @(negedge clk);
        n_assert++;
        if (b_pe_en !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_in_compute: pe_en %b required 1", b_pe_en);
        end
        #2;
        b_rst_n = 1'b0;
        #1;
        n_assert++;
        if (b_vec() !== 12'd0 || b_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_outputs: %b required 0", b_vec());
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        n_assert++;
        if (b_stall !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid_stall: %0d required 0", b_stall);
        end
`endif
        @(negedge clk);
        b_rst_n = 1'b1;
        idle_err = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_vec() !== 12'd0) idle_err++;
        end
        n_assert++;
        if (idle_err != 0) begin
            n_fail++; $display("FAIL reset_mid_quiet: %0d active cycles required 0", idle_err);
        end
        $display("reset mid-compute: quiet for 20 cycles after release");
        run_layer_b("after_reset", -1, lc, lw, sp, ovp, dp);
        n_assert++;
        if (ovp != TILES_B || dp != 1) begin
            n_fail++; $display("FAIL small_ifm_tiles: %0d drains %0d done, required %0d and 1", ovp, dp, TILES_B);
        end
    endtask

    initial begin
        test_reset();
        test_full_layer_default();
        test_random_dv();
        test_toggle_dv();
        test_start_in_drain();
        test_reset_mid_compute();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
